// File: rtl/ram_stream_reader.sv
// Streams a block of RAM words onto a valid/ready output.
// Read issue is credit-limited by a small output FIFO.
module ram_stream_reader #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_words,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_read_req,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_read_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state;
    logic [ADDR_WIDTH:0]   remaining;
    logic [ADDR_WIDTH:0]   total;
    logic [ADDR_WIDTH:0]   popped;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CNT_W-1:0]      inflight;
    logic [1:0]            vld;

    logic [DATA_WIDTH-1:0] fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  push;
    logic                  pop;
    logic                  full;

    // Credit uses registered inflight so a same-cycle pop never over-commits
    assign ram_read_req  = (state == S_RUN) && (remaining != '0)
                         && (inflight < CNT_W'(FIFO_DEPTH));
    assign ram_read_addr = addr;
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);

    assign push    = vld[1];
    assign m_valid = (count != '0);
    assign pop     = m_valid && m_ready;
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign m_data  = fifo[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            remaining <= '0;
            total     <= '0;
            popped    <= '0;
            addr      <= '0;
        end else begin
            if (ram_read_req) begin
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            if (pop) popped <= popped + 1'b1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_RUN;
                        addr      <= base_addr;
                        remaining <= num_words;
                        total     <= num_words;
                        popped    <= '0;
                    end
                end
                S_RUN:   if (remaining == '0) state <= S_DRAIN;
                S_DRAIN: if (popped == total) state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= '0;
            vld      <= '0;
        end else begin
            vld <= {vld[0], ram_read_req};
            case ({ram_read_req, pop})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= ram_read_data;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!reset) !(push && full)
    );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader with a 2-cycle RAM model
// and a scoreboard of expected stream words.
module tb_ram_stream_reader;

    localparam int DW = 10;
    localparam int AW = 12;
    localparam int FD = 4;

    logic          clk = 0;
    logic          reset = 0;
    logic          start = 0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   num_words = '0;
    logic          busy;
    logic          done;
    logic          ram_read_req;
    logic [AW-1:0] ram_read_addr;
    logic [DW-1:0] ram_read_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 0;

    int total_cnt = 0;
    int bad_cnt = 0;

    always #5 clk = ~clk;

    ram_stream_reader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .base_addr(base_addr),
        .num_words(num_words),
        .busy(busy),
        .done(done),
        .ram_read_req(ram_read_req),
        .ram_read_addr(ram_read_addr),
        .ram_read_data(ram_read_data),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready)
    );

    function automatic logic [DW-1:0] ram_val(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = a[DW-1:0] * 10'd37 + 10'd5;
        return v ^ {8'd0, a[AW-1:AW-2]};
    endfunction

    logic [DW-1:0] ram_d1;
    always @(posedge clk) begin
        ram_d1        <= ram_val(ram_read_addr);
        ram_read_data <= ram_d1;
    end

    logic [DW-1:0] sb_q[$];
    always @(negedge clk) begin
        logic [DW-1:0] exp_d;
        if (reset) begin
            if (m_valid && m_ready) begin
                total_cnt++;
                if (sb_q.size() == 0) begin
                    bad_cnt++;
                    $display("FAIL sb_extra: got %h, none expected", m_data);
                end else begin
                    exp_d = sb_q.pop_front();
                    if (m_data !== exp_d) begin
                        bad_cnt++;
                        $display("FAIL sb_data: got %h want %h", m_data, exp_d);
                    end
                end
            end
            if (ram_read_req) sb_q.push_back(ram_val(ram_read_addr));
        end
    end

    int o_first_valid, o_done_cyc, o_done_cnt, o_busy_cnt;
    int o_busy_first, o_busy_last, o_req_cnt, o_pop_cnt;
    int o_last_pop, o_req_hold;
    logic [AW-1:0] addr_log[$];

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n);
        @(posedge clk); #1;
        base_addr = b;
        num_words = n;
        start = 1;
    endtask

    // mode 0: ready=1, 1: random ready, 2: ready=0 through cycle 20
    task automatic observe(input int max_cyc, input int mode, input bit restart);
        bit released = 0;
        o_first_valid = -1; o_done_cyc = -1; o_done_cnt = 0;
        o_busy_cnt = 0; o_busy_first = -1; o_busy_last = -1;
        o_req_cnt = 0; o_pop_cnt = 0; o_last_pop = -1; o_req_hold = 0;
        addr_log.delete();
        for (int k = 0; k < max_cyc; k++) begin
            if (k == 1) start = 0;
            if (restart && k == 5) begin
                start = 1;
                base_addr = 12'h300;
                num_words = 13'd3;
            end
            if (restart && k == 6) start = 0;
            case (mode)
                0:       m_ready = 1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = (k > 20);
            endcase
            if (m_ready) released = 1;
            @(negedge clk);
            if (busy) begin
                o_busy_cnt++;
                if (o_busy_first < 0) o_busy_first = k;
                o_busy_last = k;
            end
            if (done) begin
                o_done_cnt++;
                o_done_cyc = k;
            end
            if (ram_read_req) begin
                o_req_cnt++;
                addr_log.push_back(ram_read_addr);
                if (!released) o_req_hold++;
            end
            if (m_valid && o_first_valid < 0) o_first_valid = k;
            if (m_valid && m_ready) begin
                o_pop_cnt++;
                o_last_pop = k;
            end
            if (o_done_cnt > 0 && k >= o_done_cyc + 2) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total_cnt += 6;
        if (busy !== 1'b0) begin bad_cnt++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin bad_cnt++; $display("FAIL rst_done: got %b want 0", done); end
        if (ram_read_req !== 1'b0) begin bad_cnt++; $display("FAIL rst_req: got %b want 0", ram_read_req); end
        if (ram_read_addr !== '0) begin bad_cnt++; $display("FAIL rst_addr: got %h want 0", ram_read_addr); end
        if (m_valid !== 1'b0) begin bad_cnt++; $display("FAIL rst_valid: got %b want 0", m_valid); end
        if (m_data !== '0) begin bad_cnt++; $display("FAIL rst_data: got %h want 0", m_data); end
        reset = 1;
    endtask

    task automatic test_basic();
        do_start(12'h010, 13'd8);
        observe(60, 0, 0);
        total_cnt += 7;
        if (o_first_valid !== 4) begin bad_cnt++; $display("FAIL basic_first_valid: got %0d want 4", o_first_valid); end
        if (o_last_pop !== 11) begin bad_cnt++; $display("FAIL basic_last_pop: got %0d want 11", o_last_pop); end
        if (o_done_cyc !== 13 || o_done_cnt !== 1) begin bad_cnt++; $display("FAIL basic_done: got cyc %0d cnt %0d want 13/1", o_done_cyc, o_done_cnt); end
        if (o_busy_first !== 1 || o_busy_last !== 13) begin bad_cnt++; $display("FAIL basic_busy_span: got %0d..%0d want 1..13", o_busy_first, o_busy_last); end
        if (o_busy_cnt !== 13) begin bad_cnt++; $display("FAIL basic_busy_cnt: got %0d want 13", o_busy_cnt); end
        if (o_pop_cnt !== 8) begin bad_cnt++; $display("FAIL basic_pops: got %0d want 8", o_pop_cnt); end
        if (sb_q.size() !== 0) begin bad_cnt++; $display("FAIL basic_sb_left: got %0d want 0", sb_q.size()); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a [4];
        exp_a = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        do_start(12'hFFE, 13'd4);
        observe(60, 0, 0);
        total_cnt += 2;
        if (addr_log.size() !== 4) begin bad_cnt++; $display("FAIL wrap_req_cnt: got %0d want 4", addr_log.size()); end
        if (o_pop_cnt !== 4) begin bad_cnt++; $display("FAIL wrap_pops: got %0d want 4", o_pop_cnt); end
        for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
            total_cnt++;
            if (addr_log[i] !== exp_a[i]) begin
                bad_cnt++;
                $display("FAIL wrap_addr%0d: got %h want %h", i, addr_log[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_start(12'h400, 13'd16);
        observe(300, 2, 0);
        total_cnt += 4;
        if (o_req_hold !== FD) begin bad_cnt++; $display("FAIL bp_held_reqs: got %0d want %0d", o_req_hold, FD); end
        if (o_pop_cnt !== 16) begin bad_cnt++; $display("FAIL bp_pops: got %0d want 16", o_pop_cnt); end
        if (o_done_cnt !== 1) begin bad_cnt++; $display("FAIL bp_done: got %0d want 1", o_done_cnt); end
        if (sb_q.size() !== 0) begin bad_cnt++; $display("FAIL bp_sb_left: got %0d want 0", sb_q.size()); end
    endtask

    task automatic test_random_full();
        do_start(12'h000, 13'd4096);
        observe(30000, 1, 0);
        total_cnt += 4;
        if (o_pop_cnt !== 4096) begin bad_cnt++; $display("FAIL rnd_pops: got %0d want 4096", o_pop_cnt); end
        if (o_done_cnt !== 1) begin bad_cnt++; $display("FAIL rnd_done: got %0d want 1", o_done_cnt); end
        if (!(o_last_pop >= 0 && o_done_cyc > o_last_pop)) begin bad_cnt++; $display("FAIL rnd_done_order: got done %0d last pop %0d", o_done_cyc, o_last_pop); end
        if (sb_q.size() !== 0) begin bad_cnt++; $display("FAIL rnd_sb_left: got %0d want 0", sb_q.size()); end
    endtask

    task automatic test_zero_and_restart();
        do_start(12'h123, 13'd0);
        observe(40, 0, 0);
        total_cnt += 3;
        if (o_req_cnt !== 0) begin bad_cnt++; $display("FAIL zero_reqs: got %0d want 0", o_req_cnt); end
        if (o_first_valid !== -1) begin bad_cnt++; $display("FAIL zero_valid: got cycle %0d want none", o_first_valid); end
        if (o_done_cyc !== 3 || o_done_cnt !== 1) begin bad_cnt++; $display("FAIL zero_done: got cyc %0d cnt %0d want 3/1", o_done_cyc, o_done_cnt); end
        do_start(12'h100, 13'd8);
        observe(60, 0, 1);
        total_cnt += 3;
        if (o_req_cnt !== 8) begin bad_cnt++; $display("FAIL rs_reqs: got %0d want 8", o_req_cnt); end
        if (o_pop_cnt !== 8) begin bad_cnt++; $display("FAIL rs_pops: got %0d want 8", o_pop_cnt); end
        if (o_done_cnt !== 1) begin bad_cnt++; $display("FAIL rs_done: got %0d want 1", o_done_cnt); end
        repeat (4) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0) begin bad_cnt++; $display("FAIL rs_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int  pops = 0;
        bit  hit = 0;
        int  stale = 0;
        do_start(12'h200, 13'd10);
        for (int k = 0; k < 40 && !hit; k++) begin
            if (k == 1) start = 0;
            m_ready = 1;
            @(negedge clk);
            if (m_valid && m_ready) pops++;
            if (pops == 5) hit = 1;
            @(posedge clk); #1;
        end
        start = 0;
        total_cnt++;
        if (!hit) begin bad_cnt++; $display("FAIL mid_reach: got %0d pops want 5", pops); end
        reset = 0;
        #1;
        total_cnt += 4;
        if (busy !== 1'b0) begin bad_cnt++; $display("FAIL mid_busy: got %b want 0", busy); end
        if (ram_read_req !== 1'b0) begin bad_cnt++; $display("FAIL mid_req: got %b want 0", ram_read_req); end
        if (m_valid !== 1'b0) begin bad_cnt++; $display("FAIL mid_valid: got %b want 0", m_valid); end
        if (ram_read_addr !== '0 || m_data !== '0) begin bad_cnt++; $display("FAIL mid_regs: got addr %h data %h want 0/0", ram_read_addr, m_data); end
        sb_q.delete();
        @(posedge clk); #1;
        reset = 1;
        repeat (4) begin
            @(negedge clk);
            if (m_valid) stale++;
        end
        total_cnt++;
        if (stale !== 0) begin bad_cnt++; $display("FAIL mid_stale: got %0d valid cycles want 0", stale); end
        do_start(12'h040, 13'd2);
        observe(40, 0, 0);
        total_cnt += 3;
        if (o_pop_cnt !== 2) begin bad_cnt++; $display("FAIL mid_new_pops: got %0d want 2", o_pop_cnt); end
        if (o_done_cnt !== 1) begin bad_cnt++; $display("FAIL mid_new_done: got %0d want 1", o_done_cnt); end
        if (sb_q.size() !== 0) begin bad_cnt++; $display("FAIL mid_sb_left: got %0d want 0", sb_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_and_restart();
        test_reset_mid();
        test_random_full();
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Read-side sequencer for the on-chip `ram` buffer. On `start` it issues `num_words` consecutive read requests from `base_addr` into the RAM's read port, absorbs the RAM's fixed 2-cycle read latency, and presents the words in address order on a valid/ready stream to the downstream compute stage. Reads are credit-throttled against an internal output FIFO, so downstream back-pressure never loses data.

## Interface
- `DATA_WIDTH`, 10: word width; must match the RAM.
- `ADDR_WIDTH`, 12: RAM address width.
- `FIFO_DEPTH`, 4: output FIFO entries, power of two, ≥2. Full throughput requires ≥4.

- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low (asserts at 0); clears all state.
- `start` in 1: one-cycle request to begin a transfer; sampled only in IDLE.
- `base_addr` in ADDR_WIDTH: first RAM address; sampled with `start`.
- `num_words` in ADDR_WIDTH+1: word count, 0..2^ADDR_WIDTH; sampled with `start`.
- `busy` out 1: high from the cycle after an accepted `start` through the `done` cycle.
- `done` out 1: one-cycle pulse after the last word is popped from the stream.
- `ram_read_req` out 1: RAM `s_read_req`.
- `ram_read_addr` out ADDR_WIDTH: RAM `s_read_addr`.
- `ram_read_data` in DATA_WIDTH: RAM `s_read_data`; valid exactly 2 cycles after the request cycle.
- `m_data` out DATA_WIDTH: stream data (FIFO head).
- `m_valid` out 1: stream valid (FIFO not empty).
- `m_ready` in 1: downstream accept. A word transfers when `m_valid && m_ready`.

## Operation
- States:
  - IDLE: `start` → RUN; `busy`=1 next cycle.
  - RUN: issues reads. Moves to DRAIN when the remaining-issue count reaches 0.
  - DRAIN: waits until `popped == num_words`, then → DONE.
  - DONE: `done`=1 for one cycle, then → IDLE.
- `num_words == 0`: path is IDLE→RUN→DRAIN→DONE with no requests issued. `done` pulses on cycle 3 after `start`.
- `ram_read_req = (state==RUN) && remaining != 0 && inflight < FIFO_DEPTH`. This is combinational from registered state.
- `ram_read_addr` = address counter. It loads `base_addr` on start and increments per request, modulo 2^ADDR_WIDTH, so it wraps from 2^ADDR_WIDTH−1 to 0.
- Return path: a 2-stage valid shift register follows `ram_read_req`. When stage 2 is high, `ram_read_data` is written into the FIFO that cycle.
- `inflight` (width clog2(FIFO_DEPTH)+1) counts words requested but not yet popped:
  - +1 on a request, −1 on a pop; both in one cycle → unchanged.
  - The credit check uses the registered value; a same-cycle pop does not count.
  - This guarantees the FIFO never overflows. A FIFO write while full is a design error, covered by an assertion.
- `start` while not IDLE is ignored. `base_addr`/`num_words` changes during a transfer have no effect.
- Order: stream words appear strictly in request order, no gaps and no duplicates.
- Reset asserted mid-transfer:
  - All outputs and state clear immediately: state=IDLE, counters 0, FIFO empty, valid pipeline 0.
  - RAM data returning after reset release is ignored, because the valid pipeline is cleared.

## Timing
- Reset values: `busy`=0, `done`=0, `ram_read_req`=0, `ram_read_addr`=0, `m_valid`=0, `m_data`=0.
- `start` high in cycle 0 (IDLE):
  - `busy` and the first `ram_read_req` are in cycle 1.
  - RAM data is valid in cycle 3.
  - First `m_valid` is in cycle 4.
- Request-to-`m_valid` latency is 3 cycles with an empty FIFO.
- With `m_ready` held at 1 and `FIFO_DEPTH`≥4: one request and one word per cycle. For N≥1 words, the last word pops in cycle N+3 and `done` is in cycle N+5.
- With `FIFO_DEPTH`=2 and `m_ready`=1: throughput is 1 word per 2 cycles.
- With `m_ready`=0: at most FIFO_DEPTH requests are issued, then `ram_read_req` stays 0 until a pop.

## Test plan
- Basic: base=0x010, N=8, `m_ready`=1 → `m_data` = mem[0x010..0x017] in order in cycles 4..11; `done` in cycle 13; `busy` high in cycles 1..13.
- Wrap: base=0xFFE, N=4 → requested addresses 0xFFE, 0xFFF, 0x000, 0x001; data in that order.
- Back-pressure: N=16, `m_ready`=0 for 20 cycles, then 1 → exactly 4 requests before release; all 16 words delivered in order; no FIFO overflow assertion.
- Random `m_ready` (50%), N=4096 (full RAM): every word delivered exactly once, in order; `done` only after the 4096th pop.
- N=0 → no `ram_read_req` and no `m_valid`; `done` in cycle 3. A `start` during busy of an N=8 run is ignored: 8 words, one `done`.
- Reset asserted (0) mid-transfer after 5 pops of N=10 → outputs at reset values at once. A new start with N=2 delivers exactly 2 correct words, with no stale data.
